// File: rtl/matmul_rr_scheduler_if.sv
// matmul_rr_scheduler_if: requester and engine signals of the scheduler; master is the scheduler side.
interface matmul_rr_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int MAT_W   = 72
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*MAT_W-1:0] a_bus;
   logic [NUM_REQ*MAT_W-1:0] b_bus;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [MAT_W-1:0]         rsp_data;
   logic                     rsp_err;
   logic                     busy;
   logic                     mm_start;
   logic [MAT_W-1:0]         mm_a;
   logic [MAT_W-1:0]         mm_b;
   logic                     mm_rst;
   logic [MAT_W-1:0]         mm_c;
   logic                     mm_done;
   modport master (
      input  req, a_bus, b_bus, mm_c, mm_done,
      output gnt, rsp_valid, rsp_data, rsp_err, busy, mm_start, mm_a, mm_b, mm_rst
   );
   modport slave (
      output req, a_bus, b_bus, mm_c, mm_done,
      input  gnt, rsp_valid, rsp_data, rsp_err, busy, mm_start, mm_a, mm_b, mm_rst
   );
endinterface

// File: rtl/matmul_rr_scheduler.sv
// matmul_rr_scheduler: round-robin sharing of one 3x3 matmul engine with a watchdog on hung jobs.
module matmul_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int MAT_W   = 72,
   parameter int TIMEOUT = 64
) (
   input logic clk,
   input logic reset,
   matmul_rr_scheduler_if.master bus
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;
   logic [1:0]         state;
   logic [PW-1:0]      ptr, owner, win;
   logic               found;
   logic [WW-1:0]      wd;
   logic [NUM_REQ-1:0] owner_oh;
   // first requester at or after the pointer, wrapping
   always_comb begin
      win = ptr;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && bus.req[(int'(ptr) + i) % NUM_REQ]) begin
            win = PW'((int'(ptr) + i) % NUM_REQ);
            found = 1'b1;
         end
      end
   end
   assign owner_oh      = NUM_REQ'(1) << owner;
   assign bus.gnt       = (state == ISSUE) ? owner_oh : '0;
   assign bus.rsp_valid = (state == RESP) ? owner_oh : '0;
   assign bus.mm_start  = (state == ISSUE);
   assign bus.busy      = (state != IDLE);
   // the engine is also reset for the response cycle of a timed-out job
   assign bus.mm_rst    = reset | ((state == RESP) & bus.rsp_err);
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         ptr          <= '0;
         owner        <= '0;
         wd           <= '0;
         bus.mm_a     <= '0;
         bus.mm_b     <= '0;
         bus.rsp_data <= '0;
         bus.rsp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|bus.req) begin
               bus.mm_a <= bus.a_bus[int'(win)*MAT_W +: MAT_W];
               bus.mm_b <= bus.b_bus[int'(win)*MAT_W +: MAT_W];
               owner    <= win;
               ptr      <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
               state    <= ISSUE;
            end
            ISSUE: begin
               wd    <= '0;
               state <= BUSY;
            end
            BUSY: begin
               wd <= wd + 1'b1;
               if (bus.mm_done) begin
                  bus.rsp_data <= bus.mm_c;
                  bus.rsp_err  <= 1'b0;
                  state        <= RESP;
               end else if (wd == WW'(TIMEOUT - 1)) begin
                  bus.rsp_data <= '0;
                  bus.rsp_err  <= 1'b1;
                  state        <= RESP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/matmul_rr_scheduler.md
Name: matmul_rr_scheduler

Overview:
- Shares one 3x3 8-bit matrix-multiply engine (start/done handshake, flattened 72-bit A/B/C) between NUM_REQ requesters using round-robin arbitration.
- Latches the winner's operands and holds them stable for the whole job, then sequences the engine's start and done signals.
- Returns the result to the owning requester, and recovers a hung engine with a watchdog.
- Sits between the requesting client blocks and the multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAT_W, 72, flattened matrix width (9 elements x 8 bits).
- TIMEOUT, 64, BUSY cycles allowed before the watchdog fires (must exceed the 38-cycle engine latency).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester request level.
- a_bus  in  NUM_REQ*MAT_W  operand A for requester r at [r*MAT_W +: MAT_W].
- b_bus  in  NUM_REQ*MAT_W  operand B, same packing.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: operands captured.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse to the owner.
- rsp_data  out  MAT_W  result C, valid with rsp_valid.
- rsp_err  out  1  qualifies rsp_valid: watchdog expired, rsp_data = 0.
- busy  out  1  high in every state except IDLE.
- mm_start  out  1  engine start.
- mm_a  out  MAT_W  registered operand A to the engine.
- mm_b  out  MAT_W  registered operand B to the engine.
- mm_rst  out  1  engine reset.
- mm_c  in  MAT_W  engine result.
- mm_done  in  1  engine done (sticky high until the next start is accepted).

Behaviour:
- Clock and reset:
  - Single clock domain. All state updates on the rising edge of clk.
  - reset is sampled synchronously and is active-high.
- Reset values:
  - gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, mm_start=0, mm_a=0, mm_b=0.
  - State=IDLE, rr pointer=0, watchdog counter=0.
  - mm_rst=1 while reset is high, so the engine resets with the scheduler.
- Reset mid-job: the job is dropped, no rsp_valid is issued, and the pointer returns to 0.
- State machine: IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If req != 0, pick the winner w: the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - At the clock edge, register mm_a/mm_b from slot w, store owner=w, set the pointer to (w+1) mod NUM_REQ, and go to ISSUE.
  - mm_done is ignored in IDLE.
- ISSUE (1 cycle):
  - gnt[owner]=1 and mm_start=1. Next state is BUSY and the watchdog clears to 0.
  - The requester must drop req[owner] the cycle after gnt. A req still high when the scheduler is next in IDLE is a new job.
- BUSY:
  - mm_a and mm_b are held constant. The watchdog increments each cycle.
  - If mm_done=1, capture rsp_data<=mm_c, set rsp_err<=0, and go to RESP. mm_done has priority over the watchdog in the same cycle.
  - Otherwise, if watchdog==TIMEOUT-1: rsp_data<=0, rsp_err<=1, mm_rst=1 for the next cycle (RESP), then go to RESP.
- RESP (1 cycle):
  - rsp_valid[owner]=1, with rsp_data and rsp_err stable.
  - Next state is IDLE. Back-to-back jobs need at least one IDLE cycle.
- Latency with the 3x3 engine:
  - The engine takes 38 edges from start sample to done high.
  - rsp_valid asserts exactly 39 cycles after the gnt cycle.
  - Throughput is one job per 41 cycles.
- Fairness:
  - req arriving during ISSUE, BUSY or RESP waits. No requester is skipped.
  - With all requesters active, grants rotate strictly 0,1,2,3,0,...
- Simultaneous events: new req while RESP is active is arbitrated in the following IDLE cycle, using the already-updated pointer.
- Width rule: rsp_data passes mm_c through unchanged. Each element is mod-256, as produced by the engine.

Test Plan:
- Reset check: assert reset for 2 cycles mid-job (in BUSY) -> all outputs 0, mm_rst=1 during reset, no rsp_valid, and the next grant goes to requester 0.
- Single job: req[2] with A=identity, B elements 1..9 -> gnt=4'b0100 for 1 cycle; mm_start pulses the same cycle; 39 cycles later rsp_valid=4'b0100, rsp_data=B, rsp_err=0.
- Multi-element product: req[0] with A all-2, B all-3 -> every element is 18 (0x12); rsp_valid[0] only.
- Round-robin: req=4'b1111 held and re-raised after each gnt -> grant order 0,1,2,3,0; each grant 41 cycles apart.
- Pointer wrap: pointer at 3, req=4'b0011 -> gnt[0], then gnt[1]; requester 3 not granted.
- Watchdog: engine stub holds mm_done=0 -> after 64 BUSY cycles, mm_rst pulses 1 cycle and rsp_valid[owner]=1 with rsp_err=1, rsp_data=0; the next job proceeds normally.
